// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared funct3 codes, FSM state type and size helpers for the LSU
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  function automatic logic [3:0] size_to_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   size_to_mask = 4'b0001;
      2'b01:   size_to_mask = 4'b0011;
      2'b10:   size_to_mask = 4'b1111;
      default: size_to_mask = 4'b0000;
    endcase
  endfunction

  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      2'b00:   size_bytes = 3'd1;
      2'b01:   size_bytes = 3'd2;
      default: size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// rtl/load_extend.sv - combinational sign/zero extension of lane-0 aligned load data
module load_extend
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [31:0] rdata,
  output logic [31:0] ext
);

  always_comb begin
    ext = rdata;
    case (funct3)
      F3_B:    ext = {{24{rdata[7]}}, rdata[7:0]};
      F3_BU:   ext = {24'd0, rdata[7:0]};
      F3_H:    ext = {{16{rdata[15]}}, rdata[15:0]};
      F3_HU:   ext = {16'd0, rdata[15:0]};
      default: ext = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// rtl/lsu_mem_master.sv - single-outstanding load/store initiator for the byte-lane data memory
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int ADDR_W        = 11,
  parameter int MEM_BYTES     = 2048,
  parameter int MISALIGN_TRAP = 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [2:0]        i_req_funct3,
  input  logic [31:0]       i_req_addr,
  input  logic [31:0]       i_req_wdata,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [31:0]       o_rsp_rdata,
  output logic              o_rsp_err,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic [3:0]        o_mem_mask,
  output logic              o_mem_wren,
  input  logic [31:0]       i_mem_rdata
);

  state_t state, state_next;

  logic        cap_we;
  logic [2:0]  cap_f3;
  logic [31:0] ext_data;

  logic        f3_legal;
  logic        out_of_range;
  logic        misaligned;
  logic        req_err;
  logic        accept;
  logic [2:0]  nbytes;
  logic [32:0] last_byte;

  // Range check in 33 bits so addr near 2^32 cannot wrap back into range
  always_comb begin
    if (i_req_we)
      f3_legal = (i_req_funct3 == F3_B) || (i_req_funct3 == F3_H) || (i_req_funct3 == F3_W);
    else
      f3_legal = (i_req_funct3 == F3_B) || (i_req_funct3 == F3_H) || (i_req_funct3 == F3_W) ||
                 (i_req_funct3 == F3_BU) || (i_req_funct3 == F3_HU);
    nbytes       = size_bytes(i_req_funct3[1:0]);
    last_byte    = {1'b0, i_req_addr} + 33'(nbytes) - 33'd1;
    out_of_range = ((i_req_addr >> ADDR_W) != 32'd0) || (last_byte > 33'(MEM_BYTES - 1));
    misaligned   = (MISALIGN_TRAP != 0) &&
                   (((i_req_funct3[1:0] == 2'b01) && i_req_addr[0]) ||
                    ((i_req_funct3[1:0] == 2'b10) && (i_req_addr[1:0] != 2'b00)));
    req_err      = !f3_legal || out_of_range || misaligned;
    accept       = (state == IDLE) && i_req_valid;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (i_req_valid) state_next = req_err ? RESP : ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    if (i_rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  load_extend u_load_extend (
    .funct3 (cap_f3),
    .rdata  (i_mem_rdata),
    .ext    (ext_data)
  );

  // Memory outputs default to 0 each cycle so they are only nonzero during ACCESS
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      cap_we      <= 1'b0;
      cap_f3      <= 3'd0;
      o_mem_addr  <= '0;
      o_mem_wdata <= 32'd0;
      o_mem_mask  <= 4'd0;
      o_mem_wren  <= 1'b0;
      o_rsp_rdata <= 32'd0;
      o_rsp_err   <= 1'b0;
    end else begin
      o_mem_addr  <= '0;
      o_mem_wdata <= 32'd0;
      o_mem_mask  <= 4'd0;
      o_mem_wren  <= 1'b0;
      if (accept) begin
        cap_we      <= i_req_we;
        cap_f3      <= i_req_funct3;
        o_rsp_err   <= req_err;
        o_rsp_rdata <= 32'd0;
        if (!req_err) begin
          o_mem_addr  <= i_req_addr[ADDR_W-1:0];
          o_mem_wdata <= i_req_wdata;
          o_mem_mask  <= size_to_mask(i_req_funct3[1:0]);
          o_mem_wren  <= i_req_we;
        end
      end
      if (state == ACCESS && !cap_we)
        o_rsp_rdata <= ext_data;
    end
  end

  assign o_req_ready = (state == IDLE);
  assign o_rsp_valid = (state == RESP);

endmodule

// File: tb/tb_lsu_mem_master.sv
// tb/tb_lsu_mem_master.sv - directed table-driven bench for lsu_mem_master with a byte-lane memory model
module tb_lsu_mem_master;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_req_valid = 1'b0;
  logic        o_req_ready;
  logic        i_req_we = 1'b0;
  logic [2:0]  i_req_funct3 = 3'd0;
  logic [31:0] i_req_addr = 32'd0;
  logic [31:0] i_req_wdata = 32'd0;
  logic        o_rsp_valid;
  logic        i_rsp_ready = 1'b0;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_err;
  logic [10:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_mask;
  logic        o_mem_wren;
  logic [31:0] i_mem_rdata;

  logic [7:0] mem [0:2047];
  int total = 0;
  int passed = 0;

  always #5 i_clk = ~i_clk;

  lsu_mem_master dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_req_we     (i_req_we),
    .i_req_funct3 (i_req_funct3),
    .i_req_addr   (i_req_addr),
    .i_req_wdata  (i_req_wdata),
    .o_rsp_valid  (o_rsp_valid),
    .i_rsp_ready  (i_rsp_ready),
    .o_rsp_rdata  (o_rsp_rdata),
    .o_rsp_err    (o_rsp_err),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wdata  (o_mem_wdata),
    .o_mem_mask   (o_mem_mask),
    .o_mem_wren   (o_mem_wren),
    .i_mem_rdata  (i_mem_rdata)
  );

  always @* begin
    for (int k = 0; k < 4; k++) begin
      logic [10:0] idx;
      idx = o_mem_addr + 11'(k);
      i_mem_rdata[8*k +: 8] = o_mem_mask[k] ? mem[idx] : 8'd0;
    end
  end

  always @(posedge i_clk) begin
    if (i_reset && o_mem_wren) begin
      for (int k = 0; k < 4; k++) begin
        if (o_mem_mask[k]) mem[o_mem_addr + 11'(k)] <= o_mem_wdata[8*k +: 8];
      end
    end
  end

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    logic [3:0]  mask;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic run_vec(input int i, input vec_t v);
    @(negedge i_clk);
    chk($sformatf("v%0d_ready_before", i), 32'(o_req_ready), 32'd1);
    i_req_valid  = 1'b1;
    i_req_we     = v.we;
    i_req_funct3 = v.f3;
    i_req_addr   = v.addr;
    i_req_wdata  = v.wdata;
    @(posedge i_clk);
    #1;
    i_req_valid = 1'b0;
    if (v.err) begin
      chk($sformatf("v%0d_err_fast_valid", i), 32'(o_rsp_valid), 32'd1);
      chk($sformatf("v%0d_err_mask", i), 32'(o_mem_mask), 32'd0);
      chk($sformatf("v%0d_err_wren", i), 32'(o_mem_wren), 32'd0);
    end else begin
      chk($sformatf("v%0d_acc_valid", i), 32'(o_rsp_valid), 32'd0);
      chk($sformatf("v%0d_acc_mask", i), 32'(o_mem_mask), 32'(v.mask));
      chk($sformatf("v%0d_acc_wren", i), 32'(o_mem_wren), 32'(v.we));
      chk($sformatf("v%0d_acc_addr", i), 32'(o_mem_addr), 32'(v.addr[10:0]));
      chk($sformatf("v%0d_acc_wdata", i), o_mem_wdata, v.wdata);
      @(posedge i_clk);
      #1;
      chk($sformatf("v%0d_resp_mask", i), 32'(o_mem_mask), 32'd0);
      chk($sformatf("v%0d_resp_valid", i), 32'(o_rsp_valid), 32'd1);
    end
    chk($sformatf("v%0d_rdata", i), o_rsp_rdata, v.rdata);
    chk($sformatf("v%0d_err", i), 32'(o_rsp_err), 32'(v.err));
    chk($sformatf("v%0d_ready_busy", i), 32'(o_req_ready), 32'd0);
    i_rsp_ready = 1'b1;
    @(posedge i_clk);
    #1;
    i_rsp_ready = 1'b0;
    chk($sformatf("v%0d_valid_drop", i), 32'(o_rsp_valid), 32'd0);
    chk($sformatf("v%0d_wren_after", i), 32'(o_mem_wren), 32'd0);
  endtask

  initial begin
    for (int a = 0; a < 2048; a++) mem[a] = 8'd0;

    vecs.push_back('{1'b1, 3'b010, 32'h010, 32'hDEADBEEF, 1'b0, 32'h00000000, 4'b1111});
    vecs.push_back('{1'b0, 3'b010, 32'h010, 32'h0,        1'b0, 32'hDEADBEEF, 4'b1111});
    vecs.push_back('{1'b0, 3'b000, 32'h010, 32'h0,        1'b0, 32'hFFFFFFEF, 4'b0001});
    vecs.push_back('{1'b0, 3'b100, 32'h010, 32'h0,        1'b0, 32'h000000EF, 4'b0001});
    vecs.push_back('{1'b0, 3'b001, 32'h012, 32'h0,        1'b0, 32'hFFFFDEAD, 4'b0011});
    vecs.push_back('{1'b0, 3'b101, 32'h012, 32'h0,        1'b0, 32'h0000DEAD, 4'b0011});
    vecs.push_back('{1'b1, 3'b000, 32'h020, 32'h12345678, 1'b0, 32'h00000000, 4'b0001});
    vecs.push_back('{1'b0, 3'b010, 32'h020, 32'h0,        1'b0, 32'h00000078, 4'b1111});
    vecs.push_back('{1'b0, 3'b010, 32'h012, 32'h0,        1'b1, 32'h00000000, 4'b0000});
    vecs.push_back('{1'b1, 3'b010, 32'h7FE, 32'hCAFEF00D, 1'b1, 32'h00000000, 4'b0000});
    vecs.push_back('{1'b0, 3'b100, 32'h7FF, 32'h0,        1'b0, 32'h00000000, 4'b0001});
    vecs.push_back('{1'b0, 3'b011, 32'h010, 32'h0,        1'b1, 32'h00000000, 4'b0000});
    vecs.push_back('{1'b1, 3'b100, 32'h010, 32'h0,        1'b1, 32'h00000000, 4'b0000});
    vecs.push_back('{1'b0, 3'b010, 32'h800, 32'h0,        1'b1, 32'h00000000, 4'b0000});
    vecs.push_back('{1'b0, 3'b010, 32'h80000010, 32'h0,   1'b1, 32'h00000000, 4'b0000});
    vecs.push_back('{1'b0, 3'b010, 32'h7FC, 32'h0,        1'b0, 32'h00000000, 4'b1111});
    vecs.push_back('{1'b1, 3'b001, 32'h030, 32'hAAAA5555, 1'b0, 32'h00000000, 4'b0011});
    vecs.push_back('{1'b0, 3'b010, 32'h030, 32'h0,        1'b0, 32'h00005555, 4'b1111});
    vecs.push_back('{1'b0, 3'b001, 32'h031, 32'h0,        1'b1, 32'h00000000, 4'b0000});

    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_req_ready", 32'(o_req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
    chk("rst_mem_mask", 32'(o_mem_mask), 32'd0);
    chk("rst_mem_wren", 32'(o_mem_wren), 32'd0);
    chk("rst_mem_addr", 32'(o_mem_addr), 32'd0);
    chk("rst_mem_wdata", o_mem_wdata, 32'd0);
    chk("rst_rsp_rdata", o_rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(o_rsp_err), 32'd0);
    @(negedge i_clk);
    i_reset = 1'b1;

    foreach (vecs[i]) run_vec(i, vecs[i]);

    chk("mem_sb_byte20", 32'(mem[11'h020]), 32'h78);
    chk("mem_sb_byte21", 32'(mem[11'h021]), 32'h00);
    chk("mem_range_7fe", 32'(mem[11'h7FE]), 32'h00);
    chk("mem_range_7ff", 32'(mem[11'h7FF]), 32'h00);

    // Backpressure, with a second request held valid throughout
    @(negedge i_clk);
    i_req_valid = 1'b1; i_req_we = 1'b0; i_req_funct3 = 3'b010; i_req_addr = 32'h010;
    @(posedge i_clk);
    #1;
    i_req_funct3 = 3'b000; i_req_addr = 32'h020;
    chk("bp_access_mask", 32'(o_mem_mask), 32'hF);
    @(posedge i_clk);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("bp_valid_c%0d", c), 32'(o_rsp_valid), 32'd1);
      chk($sformatf("bp_rdata_c%0d", c), o_rsp_rdata, 32'hDEADBEEF);
      chk($sformatf("bp_ready_c%0d", c), 32'(o_req_ready), 32'd0);
      chk($sformatf("bp_mask_c%0d", c), 32'(o_mem_mask), 32'd0);
      @(posedge i_clk);
    end
    @(negedge i_clk);
    i_rsp_ready = 1'b1;
    @(posedge i_clk);
    #1;
    i_rsp_ready = 1'b0;
    chk("bp_hs_valid", 32'(o_rsp_valid), 32'd0);
    chk("bp_hs_ready", 32'(o_req_ready), 32'd1);
    chk("bp_hs_mask", 32'(o_mem_mask), 32'd0);
    @(posedge i_clk);
    #1;
    i_req_valid = 1'b0;
    chk("bp2_mask", 32'(o_mem_mask), 32'h1);
    chk("bp2_addr", 32'(o_mem_addr), 32'h020);
    @(posedge i_clk);
    #1;
    chk("bp2_valid", 32'(o_rsp_valid), 32'd1);
    chk("bp2_rdata", o_rsp_rdata, 32'h00000078);
    i_rsp_ready = 1'b1;
    @(posedge i_clk);
    #1;
    i_rsp_ready = 1'b0;

    // Reset asserted during the ACCESS cycle of a store
    @(negedge i_clk);
    i_req_valid = 1'b1; i_req_we = 1'b1; i_req_funct3 = 3'b010;
    i_req_addr = 32'h040; i_req_wdata = 32'h11223344;
    @(posedge i_clk);
    #1;
    i_req_valid = 1'b0;
    chk("rma_wren_in_access", 32'(o_mem_wren), 32'd1);
    i_reset = 1'b0;
    @(posedge i_clk);
    #1;
    chk("rma_req_ready", 32'(o_req_ready), 32'd1);
    chk("rma_rsp_valid", 32'(o_rsp_valid), 32'd0);
    chk("rma_mem_wren", 32'(o_mem_wren), 32'd0);
    chk("rma_mem_dropped", 32'(mem[11'h040]), 32'h00);
    @(negedge i_clk);
    i_reset = 1'b1;
    @(posedge i_clk);
    #1;
    chk("rma_after_valid", 32'(o_rsp_valid), 32'd0);
    run_vec(100, '{1'b0, 3'b010, 32'h040, 32'h0, 1'b0, 32'h00000000, 4'b1111});

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
